// File: rtl/instr_fetch_decode.sv
// Fetch sequencer and instruction decoder for the consumer side of the
// instruction RAM. Drives PC into the RAM, latches the word returned one cycle
// later, resolves JMP/JMPZ/END internally and issues everything else to the
// execution unit.
//
// Issue handshake: dec_valid is high for every cycle the sequencer sits in
// ISSUE. The decoded fields are stable during that time. The instruction
// completes on the first rising edge where exec_done is sampled high while
// dec_valid is high. dec_valid drops on the following cycle. exec_done is
// ignored at any other time.
module instr_fetch_decode #(
  parameter int PC_WIDTH    = 7,
  parameter int INSTR_WIDTH = 20,
  parameter int PROG_DEPTH  = 46
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   zero_flag,
  input  logic                   exec_done,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [3:0]             opcode,
  output logic [3:0]             reg_a,
  output logic [3:0]             reg_b,
  output logic [11:0]            imm,
  output logic [3:0]             dst,
  output logic                   dec_valid,
  output logic                   halted,
  output logic [1:0]             fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_DECODE = 3'd3,
    S_ISSUE  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMPZ = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_END  = 4'b1110;
  localparam logic [3:0] OP_ILL0 = 4'b0000;
  localparam logic [3:0] OP_ILL1 = 4'b0001;
  localparam logic [3:0] OP_ILLF = 4'b1111;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_OVERRUN = 2'b10;

  // One extra bit so PC+1 and jump targets can be compared against the
  // program depth without wrapping.
  localparam logic [PC_WIDTH:0] DEPTH_W = (PC_WIDTH+1)'(PROG_DEPTH);

  state_t                  state;
  state_t                  state_nxt;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [PC_WIDTH-1:0]     pc_nxt;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [1:0]              fault_q;
  logic [1:0]              fault_nxt;
  logic [PC_WIDTH:0]       pc_inc;
  logic [PC_WIDTH:0]       jmp_target;
  logic [PC_WIDTH:0]       cand_pc;
  logic                    cand_en;

  assign pc_inc     = {1'b0, pc_q} + {{PC_WIDTH{1'b0}}, 1'b1};
  assign jmp_target = {{(PC_WIDTH-5){1'b0}}, ir[15:10]};

  // State, PC and fault registers; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc_q    <= '0;
      fault_q <= FAULT_NONE;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      fault_q <= fault_nxt;
    end
  end

  // Instruction register captures the RAM word while it is valid in LATCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
    end else if (state == S_LATCH) begin
      ir <= instr_in;
    end
  end

  // Next-state, next-PC and fault selection, including the overrun check
  // shared by DECODE jumps and ISSUE completion.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    fault_nxt = fault_q;
    cand_pc   = '0;
    cand_en   = 1'b0;
    case (state)
      S_IDLE: begin
        pc_nxt = '0;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH:  state_nxt = S_LATCH;
      S_LATCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (ir[19:16])
          OP_ILL0, OP_ILL1, OP_ILLF: begin
            fault_nxt = FAULT_ILLEGAL;
            state_nxt = S_HALT;
          end
          OP_END: state_nxt = S_HALT;
          OP_JMP: begin
            cand_pc = jmp_target;
            cand_en = 1'b1;
          end
          OP_JMPZ: begin
            cand_pc = zero_flag ? jmp_target : pc_inc;
            cand_en = 1'b1;
          end
          default: state_nxt = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (exec_done) begin
          cand_pc = pc_inc;
          cand_en = 1'b1;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase

    if (cand_en) begin
      if (cand_pc >= DEPTH_W) begin
        fault_nxt = FAULT_OVERRUN;
        state_nxt = S_HALT;
      end else begin
        pc_nxt    = cand_pc[PC_WIDTH-1:0];
        state_nxt = S_FETCH;
      end
    end
  end

  assign PC        = pc_q;
  assign fault     = fault_q;
  assign dec_valid = (state == S_ISSUE);
  assign halted    = (state == S_HALT);
  assign opcode    = ir[19:16];
  assign reg_a     = ir[15:12];
  assign reg_b     = ir[11:8];
  assign imm       = ir[15:4];
  assign dst       = ir[3:0];

endmodule
